// File: rtl/elem_unpack.sv
// Splits a packed word into its valid elements and streams them out one per cycle.
// Final-element handshake may reload the next word directly, so consecutive words have no bubble.
module elem_unpack #(
  parameter int W_WORD = 32,
  parameter int W_ELEM = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [W_WORD-1:0]                 word_in,
  input  logic [$clog2(W_WORD/W_ELEM):0]    word_cnt,
  input  logic                              word_last,
  input  logic                              word_valid,
  output logic                              word_ready,
  output logic signed [W_ELEM-1:0]          elem_out,
  output logic [$clog2(W_WORD/W_ELEM)-1:0]  elem_idx,
  output logic                              elem_last,
  output logic                              elem_valid,
  input  logic                              elem_ready
);

  localparam int N  = W_WORD / W_ELEM;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [W_WORD-1:0] word_reg;
  logic [CW-1:0]     cnt_reg;
  logic              last_reg;
  logic [IW-1:0]     idx_reg;

  logic              at_end_s;
  logic              load_s;
  logic              inc_s;
  logic              ready_s;
  logic [CW-1:0]     cnt_sat_s;

  assign at_end_s  = ({1'b0, idx_reg} == (cnt_reg - CW'(1)));
  assign cnt_sat_s = (word_cnt > CW'(N)) ? CW'(N) : word_cnt;

  // Next-state, register load/advance strobes and decoded outputs
  always_comb begin
    state_nxt  = state;
    load_s     = 1'b0;
    inc_s      = 1'b0;
    ready_s    = 1'b0;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    elem_out   = '0;
    elem_idx   = '0;
    case (state)
      IDLE: begin
        ready_s = 1'b1;
        if (word_valid && (word_cnt != CW'(0))) begin
          load_s    = 1'b1;
          state_nxt = EMIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      EMIT: begin
        elem_valid = 1'b1;
        elem_out   = word_reg[idx_reg*W_ELEM +: W_ELEM];
        elem_idx   = idx_reg;
        elem_last  = last_reg && at_end_s;
        ready_s    = elem_ready && at_end_s;
        if (elem_ready && at_end_s) begin
          // A word offered on the last element's handshake is taken immediately
          if (word_valid && (word_cnt != CW'(0))) begin
            load_s = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else if (elem_ready) begin
          inc_s = 1'b1;
        end else begin
          inc_s = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    word_ready = ready_s && !reset;
  end

  // State and word buffer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      word_reg <= '0;
      cnt_reg  <= '0;
      last_reg <= 1'b0;
      idx_reg  <= '0;
    end else begin
      state <= state_nxt;
      if (load_s) begin
        word_reg <= word_in;
        cnt_reg  <= cnt_sat_s;
        last_reg <= word_last;
        idx_reg  <= '0;
      end else if (inc_s) begin
        idx_reg <= idx_reg + IW'(1);
      end
    end
  end

endmodule

// File: doc/elem_unpack.md
ELEM_UNPACK -- requirements
Module: elem_unpack

Interface
REQ-001 SHALL have parameter W_WORD, default 32: width of packed input word.
REQ-002 SHALL have parameter W_ELEM, default 8: element width; W_WORD SHALL be an integer multiple of W_ELEM; N = W_WORD/W_ELEM elements per word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port word_in  input  W_WORD  packed elements; element 0 in bits [W_ELEM-1:0].
REQ-006 SHALL have port word_cnt  input  $clog2(N)+1  number of valid elements in word_in, counted from element 0.
REQ-007 SHALL have port word_last  input  1  word is the final word of the vector.
REQ-008 SHALL have port word_valid  input  1  upstream offers a word.
REQ-009 SHALL have port word_ready  output  1  block accepts a word this cycle.
REQ-010 SHALL have port elem_out  output  W_ELEM  current element, signed, for the downstream sign-extension stage.
REQ-011 SHALL have port elem_idx  output  $clog2(N)  position of elem_out within its word.
REQ-012 SHALL have port elem_last  output  1  elem_out is the final element of the vector.
REQ-013 SHALL have port elem_valid  output  1  elem_out is valid.
REQ-014 SHALL have port elem_ready  input  1  downstream consumes elem_out this cycle.

Function
REQ-015 SHALL implement FSM states IDLE and EMIT, plus registers word_reg, cnt_reg, last_reg, idx_reg.
REQ-016 Word handshake SHALL occur when word_valid && word_ready; element handshake SHALL occur when elem_valid && elem_ready.
REQ-017 In IDLE: word_ready=1 and elem_valid=0.
REQ-018 On word handshake with word_cnt>0: capture word_in, word_last and min(word_cnt,N); set idx_reg=0; enter EMIT next cycle (1-cycle latency to first elem_valid).
REQ-019 On word handshake with word_cnt==0: word SHALL be dropped, with no element emitted and no state change.
REQ-020 word_cnt>N SHALL be treated as N.
REQ-021 In EMIT: elem_valid=1; elem_out = word_reg[idx_reg*W_ELEM +: W_ELEM]; elem_idx=idx_reg.
REQ-022 elem_last SHALL be 1 only when in EMIT, last_reg=1 and idx_reg==cnt_reg-1.
REQ-023 In EMIT, on element handshake with idx_reg<cnt_reg-1: idx_reg increments by 1.
REQ-024 In EMIT, word_ready SHALL equal elem_ready && (idx_reg==cnt_reg-1), a combinational path giving zero-bubble back-to-back words.
REQ-025 On final-element handshake: a simultaneous word handshake with word_cnt>0 SHALL reload the registers and remain in EMIT; otherwise return to IDLE.
REQ-026 While elem_valid=1 and elem_ready=0, elem_out, elem_idx and elem_last SHALL hold stable.
REQ-027 Sustained throughput SHALL be one element per cycle when elem_ready=1.
REQ-028 Element contents SHALL pass bit-exact, with no extension or truncation.

Reset
REQ-029 While reset=1: state=IDLE, word_reg=0, cnt_reg=0, last_reg=0, idx_reg=0, elem_valid=0, elem_last=0, elem_out=0, word_ready=0.
REQ-030 Reset asserted mid-EMIT SHALL discard the buffered word; no further elements from it SHALL appear after reset release.
REQ-031 The first cycle after reset release SHALL be IDLE with word_ready=1.

Verification
REQ-032 Word 0x80FF7F01, cnt=4, last=1, elem_ready=1 -> elem_out 0x01,0x7F,0xFF,0x80 on 4 consecutive cycles, idx 0..3, elem_last=1 only on 0x80.
REQ-033 Word 0x44332211 cnt=2 last=0, then 0x88776655 cnt=3 last=1 presented back-to-back -> 0x11,0x22,0x55,0x66,0x77 with no gap cycle; word_ready=1 on the 0x22 handshake cycle.
REQ-034 elem_ready held low 3 cycles while 0x7F is presented -> 0x7F, idx=1 held stable; next element 0xFF only after elem_ready=1.
REQ-035 Word cnt=0 accepted in IDLE -> no elem_valid; a following word cnt=1 0x000000AB -> single 0xAB, elem_last per word_last.
REQ-036 reset pulsed after 2 of 4 elements emitted -> elem_valid=0 during reset; after release word_ready=1 and no residual elements.
REQ-037 word_cnt=7 with N=4 -> exactly 4 elements emitted.
